// File: rtl/aes_inv_cipher_iter.sv
// rtl/aes_inv_cipher_iter.sv - iterative AES inverse cipher, one inverse round per clock
module aes_inv_cipher_iter #(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [127:0]           in_data,
    input  logic [128*(Nr+1)-1:0]  key_sched,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [127:0]           out_data
);
    localparam int KW = 128 * (Nr + 1);
    localparam int SW = 128 * Nr;
    localparam int RW = $clog2(Nr);

    if (!((Nk == 4 && Nr == 10) || (Nk == 6 && Nr == 12) || (Nk == 8 && Nr == 14))) begin : g_cfg_check
        $error("aes_inv_cipher_iter: unsupported Nk/Nr pair");
    end

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xt(a);
        x4 = xt(x2);
        x8 = xt(x4);
        return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[0] ? a : 8'h00);
    endfunction

    // Byte i of a block sits at [127-8*i -: 8]; column c holds bytes 4c..4c+3.
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   b;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                b = s[127 - 8 * (4 * ((c + 4 - r) % 4) + r) -: 8];
                o[127 - 8 * (4 * c + r) -: 8] = INV_SBOX[2047 - 8 * int'(b) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            o[127 - 32 * c -: 8] = gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9);
            o[119 - 32 * c -: 8] = gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd);
            o[111 - 32 * c -: 8] = gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb);
            o[103 - 32 * c -: 8] = gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he);
        end
        return o;
    endfunction

    state_e          state_q;
    logic [RW-1:0]   rnd_q;
    logic [127:0]    blk_q;
    logic [SW-1:0]   ks_q;
    logic [127:0]    out_data_q;
    logic            out_valid_q;
    logic            in_ready_q;

    logic [127:0]    rk_sel;
    logic [127:0]    added;
    logic [127:0]    mixed;

    // rk[Nr] is consumed at accept, so only rk[0..Nr-1] are kept; rk[r] is at the top for r=0.
    always_comb begin
        rk_sel = ks_q[SW - 1 - 128 * int'(rnd_q) -: 128];
        added  = inv_shift_sub(blk_q) ^ rk_sel;
        mixed  = inv_mix_columns(added);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rnd_q       <= '0;
            blk_q       <= '0;
            ks_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        ks_q       <= key_sched[KW-1:128];
                        blk_q      <= in_data ^ key_sched[127:0];
                        rnd_q      <= RW'(Nr - 1);
                        in_ready_q <= 1'b0;
                        state_q    <= ROUND;
                    end
                end
                ROUND: begin
                    if (rnd_q != '0) begin
                        blk_q <= mixed;
                        rnd_q <= rnd_q - RW'(1);
                    end else begin
                        out_data_q  <= added;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// tb/tb_aes_inv_cipher_iter.sv - directed self-checking bench for aes_inv_cipher_iter
module tb_aes_inv_cipher_iter;
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT10 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT10 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [191:0] K192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [127:0] CT12 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT14 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT2  = 128'h00112233445566778899aabbccddeeff;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic v10, r10, ov10, ordy10;
    logic [127:0]  d10, od10;
    logic [1407:0] ks10;
    logic v12, r12, ov12, ordy12;
    logic [127:0]  d12, od12;
    logic [1663:0] ks12;
    logic v14, r14, ov14, ordy14;
    logic [127:0]  d14, od14;
    logic [1919:0] ks14;

    aes_inv_cipher_iter #(.Nk(4), .Nr(10)) u10 (
        .clk(clk), .rst_n(rst_n), .in_valid(v10), .in_ready(r10), .in_data(d10), .key_sched(ks10),
        .out_valid(ov10), .out_ready(ordy10), .out_data(od10));
    aes_inv_cipher_iter #(.Nk(6), .Nr(12)) u12 (
        .clk(clk), .rst_n(rst_n), .in_valid(v12), .in_ready(r12), .in_data(d12), .key_sched(ks12),
        .out_valid(ov12), .out_ready(ordy12), .out_data(od12));
    aes_inv_cipher_iter #(.Nk(8), .Nr(14)) u14 (
        .clk(clk), .rst_n(rst_n), .in_valid(v14), .in_ready(r14), .in_data(d14), .key_sched(ks14),
        .out_valid(ov14), .out_ready(ordy14), .out_data(od14));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] sb(input logic [7:0] b);
        return SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
    endfunction

    // Key schedule, left-aligned: word 0 at the MSBs, matching the key_sched bus layout.
    function automatic logic [1919:0] expand(input logic [255:0] key, input int nk, input int nr);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] res;
        rc  = 8'h01;
        res = '0;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                w[i] = key[255 - 32 * i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = xt(rc);
                end else if (nk > 6 && i % nk == 4) begin
                    t = subw(t);
                end
                w[i] = w[i-nk] ^ t;
            end
            res[1919 - 32 * i -: 32] = w[i];
        end
        return res;
    endfunction

    // Forward AES-128 cipher, used to confirm a plaintext whose value is not tabulated.
    function automatic logic [127:0] encrypt10(input logic [127:0] pt, input logic [1407:0] ks);
        logic [127:0] s, t;
        logic [7:0]   a0, a1, a2, a3;
        s = pt ^ ks[1407 -: 128];
        for (int r = 1; r <= 10; r++) begin
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++)
                    t[127 - 8 * (4 * c + q) -: 8] = sb(s[127 - 8 * (4 * ((c + q) % 4) + q) -: 8]);
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[127 - 32 * c -: 8];
                    a1 = t[119 - 32 * c -: 8];
                    a2 = t[111 - 32 * c -: 8];
                    a3 = t[103 - 32 * c -: 8];
                    t[127 - 32 * c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    t[119 - 32 * c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    t[111 - 32 * c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    t[103 - 32 * c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            s = t ^ ks[1407 - 128 * r -: 128];
        end
        return s;
    endfunction

    task automatic scramble10();
        d10 = {$urandom(), $urandom(), $urandom(), $urandom()};
        for (int i = 0; i < 44; i++) ks10[32 * i +: 32] = $urandom();
    endtask

    task automatic accept10(input logic [127:0] ct, input logic [1407:0] ks);
        v10  = 1'b1;
        d10  = ct;
        ks10 = ks;
        @(posedge clk);
        #1;
        v10 = 1'b0;
        scramble10();
    endtask

    task automatic wait_out10(output int n);
        n = 0;
        while (ov10 !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    logic [1919:0] full;
    logic [1407:0] k10s;
    int n, busy;

    initial begin
        rst_n = 1'b0;
        v10 = 1'b0; v12 = 1'b0; v14 = 1'b0;
        ordy10 = 1'b1; ordy12 = 1'b1; ordy14 = 1'b1;
        d10 = 'x; ks10 = 'x; d12 = '0; ks12 = '0; d14 = '0; ks14 = '0;
        full = expand({K128, 128'h0}, 4, 10);
        k10s = full[1919 -: 1408];

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", r10, 1);
        chk("rst_out_valid", ov10, 0);
        chk("rst_out_data", od10, 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_x_in_ready", r10, 1);
        chk("idle_x_out_data", od10, 0);

        // AES-128 FIPS-197 vector with the consumer always ready
        accept10(CT10, k10s);
        chk("t1_busy", r10, 0);
        wait_out10(n);
        chk("t1_latency", n, 10);
        chk("t1_plain", od10, PT10);
        @(posedge clk);
        #1;
        chk("t1_valid_drop", ov10, 0);
        chk("t1_ready_back", r10, 1);
        chk("t1_data_kept", od10, PT10);

        // AES-192
        full = expand({K192, 64'h0}, 6, 12);
        v12 = 1'b1; d12 = CT12; ks12 = full[1919 -: 1664];
        @(posedge clk);
        #1;
        v12 = 1'b0; d12 = '1; ks12 = '1;
        n = 0;
        while (ov12 !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        chk("t12_latency", n, 12);
        chk("t12_plain", od12, PT2);

        // AES-256
        full = expand(K256, 8, 14);
        v14 = 1'b1; d14 = CT14; ks14 = full;
        @(posedge clk);
        #1;
        v14 = 1'b0; d14 = '1; ks14 = '1;
        n = 0;
        while (ov14 !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        chk("t14_latency", n, 14);
        chk("t14_plain", od14, PT2);

        // Backpressure with an intruding block offered while busy
        ordy10 = 1'b0;
        accept10(CT10, k10s);
        n = 0;
        while (ov10 !== 1'b1 && n < 40) begin
            v10 = (n == 3);
            @(posedge clk);
            #1;
            n++;
        end
        v10 = 1'b0;
        chk("bp_latency", n, 10);
        chk("bp_plain", od10, PT10);
        for (int i = 0; i < 6; i++) begin
            v10 = (i == 2);
            @(posedge clk);
            #1;
            chk("bp_hold_valid", ov10, 1);
            chk("bp_hold_data", od10, PT10);
            chk("bp_hold_ready", r10, 0);
        end
        v10 = 1'b0;
        ordy10 = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", ov10, 0);
        chk("bp_release_ready", r10, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("bp_not_queued_ready", r10, 1);
        chk("bp_not_queued_valid", ov10, 0);

        // Back-to-back: second block offered as soon as the first result appears
        accept10(CT10, k10s);
        busy = 0;
        while (r10 !== 1'b1 && busy < 40) begin
            busy++;
            if (ov10 === 1'b1) begin
                chk("b2b_first_plain", od10, PT10);
                v10 = 1'b1; d10 = '0; ks10 = k10s;
            end
            @(posedge clk);
            #1;
        end
        chk("b2b_busy_cycles", busy, 11);
        @(posedge clk);
        #1;
        v10 = 1'b0;
        scramble10();
        chk("b2b_second_accept", r10, 0);
        wait_out10(n);
        chk("b2b_second_latency", n, 10);
        chk("b2b_second_reenc", encrypt10(od10, k10s), 128'h0);

        // Asynchronous reset in the middle of a block
        accept10(CT10, k10s);
        repeat (5) @(posedge clk);
        #4;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", ov10, 0);
        chk("rst_mid_data", od10, 0);
        chk("rst_mid_ready", r10, 1);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        accept10(CT10, k10s);
        wait_out10(n);
        chk("post_rst_latency", n, 10);
        chk("post_rst_plain", od10, PT10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
